// File: rtl/accum_stack.sv
// Accumulator with ALU ops, carry/overflow flags, optional unsigned saturation
// and a small LIFO for saving/restoring the accumulator.
module accum_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SAT   = 0,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] data,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_ADC    = 4'h4;
  localparam logic [3:0] OP_AND    = 4'h5;
  localparam logic [3:0] OP_OR     = 4'h6;
  localparam logic [3:0] OP_XOR    = 4'h7;
  localparam logic [3:0] OP_SHL    = 4'h8;
  localparam logic [3:0] OP_SHR    = 4'h9;
  localparam logic [3:0] OP_PUSH   = 4'hA;
  localparam logic [3:0] OP_POP    = 4'hB;
  localparam logic [3:0] OP_SWAP   = 4'hC;
  localparam logic [3:0] OP_CLR    = 4'hD;
  localparam logic [3:0] OP_CLRERR = 4'hE;

  logic [WIDTH-1:0] a_q, a_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [LW-1:0]    level_q, level_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             st_we;
  logic [IW-1:0]    st_idx;
  logic [WIDTH-1:0] st_val;

  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [LW-1:0]    level_m1;
  logic [IW-1:0]    push_idx;
  logic [IW-1:0]    top_idx;
  logic             is_full;
  logic             is_empty;

  assign cin      = (op == OP_ADC) & carry_q;
  assign sum      = {1'b0, a_q} + {1'b0, writedata} + {{WIDTH{1'b0}}, cin};
  assign diff     = {1'b0, a_q} - {1'b0, writedata};
  assign level_m1 = level_q - LW'(1);
  assign push_idx = level_q[IW-1:0];
  assign top_idx  = level_m1[IW-1:0];
  assign is_full  = (level_q == LW'(DEPTH));
  assign is_empty = (level_q == '0);

  always_comb begin
    a_d     = a_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    level_d = level_q;
    err_d   = err_q;
    st_we   = 1'b0;
    st_idx  = push_idx;
    st_val  = a_q;
    if (en) begin
      case (op)
        OP_LOAD: a_d = writedata;
        OP_ADD, OP_ADC: begin
          // Flags always describe the unclamped result, even when saturating.
          a_d     = ((SAT != 0) && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
          ovf_d   = (a_q[WIDTH-1] == writedata[WIDTH-1]) &&
                    (sum[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_SUB: begin
          a_d     = ((SAT != 0) && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
          carry_d = diff[WIDTH];
          ovf_d   = (a_q[WIDTH-1] != writedata[WIDTH-1]) &&
                    (diff[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_AND: a_d = a_q & writedata;
        OP_OR:  a_d = a_q | writedata;
        OP_XOR: a_d = a_q ^ writedata;
        OP_SHL: begin
          a_d     = {a_q[WIDTH-2:0], 1'b0};
          carry_d = a_q[WIDTH-1];
          ovf_d   = a_q[WIDTH-1] ^ a_q[WIDTH-2];
        end
        OP_SHR: begin
          a_d     = {1'b0, a_q[WIDTH-1:1]};
          carry_d = a_q[0];
          ovf_d   = 1'b0;
        end
        OP_PUSH: begin
          if (is_full) begin
            err_d = 1'b1;
          end else begin
            st_we   = 1'b1;
            level_d = level_q + LW'(1);
          end
        end
        OP_POP: begin
          if (is_empty) begin
            err_d = 1'b1;
          end else begin
            a_d     = stack_q[top_idx];
            level_d = level_m1;
          end
        end
        OP_SWAP: begin
          if (is_empty) begin
            err_d = 1'b1;
          end else begin
            a_d    = stack_q[top_idx];
            st_we  = 1'b1;
            st_idx = top_idx;
          end
        end
        OP_CLR: begin
          a_d     = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        OP_CLRERR: err_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset; occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && st_we) stack_q[st_idx] <= st_val;
  end

  assign data  = a_q;
  assign zero  = (a_q == '0);
  assign neg   = a_q[WIDTH-1];
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign level = level_q;
  assign full  = is_full;
  assign empty = is_empty;
  assign err   = err_q;

endmodule

// File: tb/tb_accum_stack.sv
// Bench for accum_stack: a wrapping and a saturating instance share stimulus and
// are checked every cycle against an integer-arithmetic reference model.
module tb_accum_stack;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] op;
  logic [7:0] wd;

  logic [7:0] o_data  [2];
  logic       o_zero  [2];
  logic       o_neg   [2];
  logic       o_carry [2];
  logic       o_ovf   [2];
  logic [2:0] o_level [2];
  logic       o_full  [2];
  logic       o_empty [2];
  logic       o_err   [2];

  int n_vec;
  int n_err;
  bit chk_on;

  // reference state per instance (0 = wrapping, 1 = saturating)
  int m_a   [2];
  int m_c   [2];
  int m_v   [2];
  int m_err [2];
  int m_stk [2][$];

  accum_stack #(.WIDTH(8), .DEPTH(4), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .op(op), .writedata(wd),
    .data(o_data[0]), .zero(o_zero[0]), .neg(o_neg[0]), .carry(o_carry[0]),
    .ovf(o_ovf[0]), .level(o_level[0]), .full(o_full[0]), .empty(o_empty[0]),
    .err(o_err[0])
  );

  accum_stack #(.WIDTH(8), .DEPTH(4), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .op(op), .writedata(wd),
    .data(o_data[1]), .zero(o_zero[1]), .neg(o_neg[1]), .carry(o_carry[1]),
    .ovf(o_ovf[1]), .level(o_level[1]), .full(o_full[1]), .empty(o_empty[1]),
    .err(o_err[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int s, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", name, s, act, exp, $time);
    end
  endtask

  function automatic int to_signed8(input int u);
    return (u >= 128) ? u - 256 : u;
  endfunction

  // reference model: applies the current inputs to the model state of one instance
  task automatic model_step(input int s);
    int ua, ud, r, sr, ci;
    bit sat;
    sat = (s == 1);
    if (rst) begin
      m_a[s] = 0; m_c[s] = 0; m_v[s] = 0; m_err[s] = 0;
      m_stk[s].delete();
      return;
    end
    if (!en) return;
    ua = m_a[s];
    ud = int'(wd);
    case (op)
      4'h1: m_a[s] = ud;
      4'h2, 4'h4: begin
        ci = (op == 4'h4) ? m_c[s] : 0;
        r  = ua + ud + ci;
        sr = to_signed8(ua) + to_signed8(ud) + ci;
        m_c[s] = (r > 255) ? 1 : 0;
        m_v[s] = (sr > 127 || sr < -128) ? 1 : 0;
        m_a[s] = (sat && r > 255) ? 255 : r % 256;
      end
      4'h3: begin
        r  = ua - ud;
        sr = to_signed8(ua) - to_signed8(ud);
        m_c[s] = (r < 0) ? 1 : 0;
        m_v[s] = (sr > 127 || sr < -128) ? 1 : 0;
        m_a[s] = (sat && r < 0) ? 0 : (r + 256) % 256;
      end
      4'h5: m_a[s] = int'(8'(ua) & wd);
      4'h6: m_a[s] = int'(8'(ua) | wd);
      4'h7: m_a[s] = int'(8'(ua) ^ wd);
      4'h8: begin
        sr = to_signed8(ua) * 2;
        m_c[s] = (ua * 2 > 255) ? 1 : 0;
        m_v[s] = (sr > 127 || sr < -128) ? 1 : 0;
        m_a[s] = (ua * 2) % 256;
      end
      4'h9: begin
        m_c[s] = ua % 2;
        m_v[s] = 0;
        m_a[s] = ua / 2;
      end
      4'hA: if (m_stk[s].size() == 4) m_err[s] = 1; else m_stk[s].push_back(ua);
      4'hB: if (m_stk[s].size() == 0) m_err[s] = 1; else m_a[s] = m_stk[s].pop_back();
      4'hC: begin
        if (m_stk[s].size() == 0) m_err[s] = 1;
        else begin
          m_a[s] = m_stk[s].pop_back();
          m_stk[s].push_back(ua);
        end
      end
      4'hD: begin m_a[s] = 0; m_c[s] = 0; m_v[s] = 0; end
      4'hE: m_err[s] = 0;
      default: ;
    endcase
  endtask

  // driver: present inputs on the falling edge, advance the model on the rising edge
  task automatic drive(input bit r, input bit e, input logic [3:0] o, input logic [7:0] d);
    @(negedge clk);
    rst = r; en = e; op = o; wd = d;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [7:0] d);
    drive(1'b0, 1'b1, o, d);
  endtask

  // scoreboard compare on every falling edge once reset has been applied
  always @(negedge clk) begin
    if (chk_on) begin
      for (int s = 0; s < 2; s++) begin
        chk("data",  s, int'(o_data[s]),  m_a[s]);
        chk("zero",  s, int'(o_zero[s]),  (m_a[s] == 0) ? 1 : 0);
        chk("neg",   s, int'(o_neg[s]),   (m_a[s] >= 128) ? 1 : 0);
        chk("carry", s, int'(o_carry[s]), m_c[s]);
        chk("ovf",   s, int'(o_ovf[s]),   m_v[s]);
        chk("level", s, int'(o_level[s]), m_stk[s].size());
        chk("full",  s, int'(o_full[s]),  (m_stk[s].size() == 4) ? 1 : 0);
        chk("empty", s, int'(o_empty[s]), (m_stk[s].size() == 0) ? 1 : 0);
        chk("err",   s, int'(o_err[s]),   m_err[s]);
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; chk_on = 0;
    rst = 1'b1; en = 1'b0; op = 4'h0; wd = 8'h00;
    drive(1'b1, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 4'h0, 8'h00);
    chk_on = 1;
    chk("rst_data", 0, int'(o_data[0]), 0);
    chk("rst_empty", 0, int'(o_empty[0]), 1);

    // arithmetic and saturation
    do_op(4'h1, 8'hF0); do_op(4'h2, 8'h20);
    chk("add_data", 0, int'(o_data[0]), 'h10);
    chk("add_carry", 0, int'(o_carry[0]), 1);
    chk("add_ovf", 0, int'(o_ovf[0]), 0);
    chk("sat_add_data", 1, int'(o_data[1]), 'hFF);
    chk("sat_add_carry", 1, int'(o_carry[1]), 1);
    do_op(4'h4, 8'h00);
    chk("adc_data", 0, int'(o_data[0]), 'h11);
    chk("adc_carry", 0, int'(o_carry[0]), 0);
    do_op(4'h1, 8'h7F); do_op(4'h2, 8'h01);
    chk("ovf_data", 0, int'(o_data[0]), 'h80);
    chk("ovf_flag", 0, int'(o_ovf[0]), 1);
    chk("ovf_neg", 0, int'(o_neg[0]), 1);
    do_op(4'h1, 8'h05); do_op(4'h3, 8'h09);
    chk("sub_wrap", 0, int'(o_data[0]), 'hFC);
    chk("sat_sub_data", 1, int'(o_data[1]), 0);
    chk("sat_sub_carry", 1, int'(o_carry[1]), 1);
    chk("sat_sub_zero", 1, int'(o_zero[1]), 1);

    // stack fill, overflow, drain, underflow
    do_op(4'h1, 8'h11); do_op(4'hA, 8'h00);
    do_op(4'h1, 8'h22); do_op(4'hA, 8'h00);
    do_op(4'h1, 8'h33); do_op(4'hA, 8'h00);
    do_op(4'h1, 8'h44); do_op(4'hA, 8'h00);
    chk("fill_full", 0, int'(o_full[0]), 1);
    chk("fill_level", 0, int'(o_level[0]), 4);
    do_op(4'hA, 8'h00);
    chk("push_full_err", 0, int'(o_err[0]), 1);
    chk("push_full_level", 0, int'(o_level[0]), 4);
    do_op(4'hB, 8'h00); chk("pop1", 0, int'(o_data[0]), 'h44);
    do_op(4'hB, 8'h00); chk("pop2", 0, int'(o_data[0]), 'h33);
    do_op(4'hB, 8'h00); chk("pop3", 0, int'(o_data[0]), 'h22);
    do_op(4'hB, 8'h00); chk("pop4", 0, int'(o_data[0]), 'h11);
    chk("drain_empty", 0, int'(o_empty[0]), 1);
    do_op(4'hE, 8'h00);
    chk("clrerr", 0, int'(o_err[0]), 0);
    do_op(4'hB, 8'h00);
    chk("pop_empty_data", 0, int'(o_data[0]), 'h11);
    chk("pop_empty_err", 0, int'(o_err[0]), 1);
    do_op(4'hE, 8'h00);

    // swap
    do_op(4'h1, 8'hAA); do_op(4'hA, 8'h00); do_op(4'h1, 8'h55); do_op(4'hC, 8'h00);
    chk("swap_data", 0, int'(o_data[0]), 'hAA);
    chk("swap_level", 0, int'(o_level[0]), 1);
    do_op(4'hB, 8'h00);
    chk("swap_pop", 0, int'(o_data[0]), 'h55);
    do_op(4'hC, 8'h00);
    chk("swap_empty_err", 0, int'(o_err[0]), 1);
    chk("swap_empty_data", 0, int'(o_data[0]), 'h55);

    // reset mid-sequence with level=2, err=1, A=0x5A
    do_op(4'hA, 8'h00); do_op(4'hA, 8'h00); do_op(4'h1, 8'h5A);
    drive(1'b1, 1'b1, 4'h2, 8'h33);
    chk("rst_mid_data", 0, int'(o_data[0]), 0);
    chk("rst_mid_level", 0, int'(o_level[0]), 0);
    chk("rst_mid_err", 0, int'(o_err[0]), 0);
    chk("rst_mid_zero", 0, int'(o_zero[0]), 1);

    // shifts and hold
    do_op(4'h1, 8'h81); do_op(4'h8, 8'h00);
    chk("shl_data", 0, int'(o_data[0]), 'h02);
    chk("shl_carry", 0, int'(o_carry[0]), 1);
    chk("shl_ovf", 0, int'(o_ovf[0]), 1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'h2, 8'h7E);
    chk("hold_data", 0, int'(o_data[0]), 'h02);
    chk("hold_carry", 0, int'(o_carry[0]), 1);
    do_op(4'h9, 8'h00);
    chk("shr_data", 0, int'(o_data[0]), 'h01);
    chk("shr_carry", 0, int'(o_carry[0]), 0);
    chk("shr_ovf", 0, int'(o_ovf[0]), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
